// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared state encoding and address-split width helpers.
`default_nettype none

package inst_cache_pkg;

  typedef enum logic [1:0] {
    LOOKUP  = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    ABORT   = 2'd3
  } state_t;

  function automatic int off_bits(input int block_size);
    return $clog2(block_size) + 2;
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int block_size);
    return 32 - off_bits(block_size) - idx_bits(lines);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetch-side and memory-side signals of the instruction cache.
`default_nettype none

interface inst_cache_if #(
  parameter int BLOCK_SIZE = 4
);
  logic [31:0]              PC;
  logic                     Flush;
  logic [31:0]              Instr;
  logic                     Stall;
  logic [31:0]              Address;
  logic                     ReadMiss;
  logic                     Abort;
  logic                     ReadReady;
  logic [32*BLOCK_SIZE-1:0] Read_data;

  // master is the cache itself, slave is the fetch stage plus memory.
  modport master (
    input  PC, Flush, ReadReady, Read_data,
    output Instr, Stall, Address, ReadMiss, Abort
  );

  modport slave (
    output PC, Flush, ReadReady, Read_data,
    input  Instr, Stall, Address, ReadMiss, Abort
  );
endinterface

`default_nettype wire

// File: rtl/inst_cache_array.sv
// inst_cache_array: valid/tag/data storage, sync write, comb read, sync valid clear.
`default_nettype none

module inst_cache_array #(
  parameter int LINES      = 16,
  parameter int BLOCK_SIZE = 4,
  parameter int TAG_W      = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(LINES)-1:0]   widx,
  input  logic [TAG_W-1:0]           wtag,
  input  logic [32*BLOCK_SIZE-1:0]   wdata,
  input  logic [$clog2(LINES)-1:0]   ridx,
  output logic                       rvalid,
  output logic [TAG_W-1:0]           rtag,
  output logic [32*BLOCK_SIZE-1:0]   rdata
);
  logic [LINES-1:0]          valid;
  logic [TAG_W-1:0]          tags [LINES];
  logic [32*BLOCK_SIZE-1:0]  data [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; an invalid line never produces a hit.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
endmodule

`default_nettype wire

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; FSM, miss address latch, hit compare.
`default_nettype none

module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  inst_cache_if.master bus
);
  localparam int OFF = off_bits(BLOCK_SIZE);
  localparam int IDX = idx_bits(LINES);
  localparam int TAG = tag_bits(LINES, BLOCK_SIZE);

  state_t                   state, state_nxt;
  logic [31:0]              miss_addr;
  logic [IDX-1:0]           pc_idx, fill_idx;
  logic [TAG-1:0]           pc_tag, fill_tag, line_tag;
  logic [32*BLOCK_SIZE-1:0] line_data;
  logic                     line_valid, hit, fill;

  assign pc_idx   = bus.PC[OFF+IDX-1:OFF];
  assign pc_tag   = bus.PC[31:OFF+IDX];
  assign fill_idx = miss_addr[OFF+IDX-1:OFF];
  assign fill_tag = miss_addr[31:OFF+IDX];

  // Fill target comes from the latched address, so PC may wander during WAIT.
  assign fill = (state == WAIT) && bus.ReadReady;

  inst_cache_array #(
    .LINES      (LINES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .TAG_W      (TAG)
  ) u_array (
    .clk    (Clk),
    .rst    (Rst),
    .we     (fill),
    .widx   (fill_idx),
    .wtag   (fill_tag),
    .wdata  (bus.Read_data),
    .ridx   (pc_idx),
    .rvalid (line_valid),
    .rtag   (line_tag),
    .rdata  (line_data)
  );

  assign hit = (state == LOOKUP) && line_valid && (line_tag == pc_tag);

  generate
    if (BLOCK_SIZE > 1) begin : g_word_sel
      logic [OFF-3:0] sel;
      assign sel       = bus.PC[OFF-1:2];
      assign bus.Instr = line_data[{sel, 5'b00000} +: 32];
    end else begin : g_single_word
      assign bus.Instr = line_data[31:0];
    end
  endgenerate

  assign bus.Stall    = ~hit;
  assign bus.Address  = miss_addr;
  assign bus.ReadMiss = (state == REQUEST);
  assign bus.Abort    = (state == ABORT);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= LOOKUP;
      miss_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOOKUP && !hit && !bus.Flush) begin
        miss_addr <= {bus.PC[31:OFF], {OFF{1'b0}}};
      end
    end
  end

  // A ReadReady coinciding with Flush in WAIT still fills and skips ABORT.
  always_comb begin
    state_nxt = state;
    case (state)
      LOOKUP:  if (!hit && !bus.Flush) state_nxt = REQUEST;
      REQUEST: state_nxt = bus.Flush ? ABORT : WAIT;
      WAIT: begin
        if (bus.ReadReady)  state_nxt = LOOKUP;
        else if (bus.Flush) state_nxt = ABORT;
      end
      ABORT:   state_nxt = LOOKUP;
      default: state_nxt = LOOKUP;
    endcase
  end
endmodule

`default_nettype wire

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed table-driven checks of inst_cache against a 20-cycle memory model.
`default_nettype none

module tb_inst_cache;
  localparam int LAT = 20;

  logic clk;
  logic rst;
  int   checks  = 0;
  int   errors  = 0;
  int   rm_cnt  = 0;
  int   ab_cnt  = 0;
  int   overlap = 0;

  inst_cache_if #(.BLOCK_SIZE(4)) bus();

  inst_cache #(.LINES(16), .BLOCK_SIZE(4)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = 32'hC0DE_0000 ^ (a + 32'(4*i));
    return r;
  endfunction

  // Memory model: latches the request, answers LAT cycles later, honours Abort and reset.
  logic        busy;
  int          cnt;
  logic [31:0] maddr;
  always @(posedge clk) begin
    bus.ReadReady <= 1'b0;
    if (rst) begin
      busy <= 1'b0;
    end else if (bus.Abort) begin
      busy <= 1'b0;
    end else if (busy) begin
      if (cnt == 1) begin
        bus.ReadReady <= 1'b1;
        bus.Read_data <= blk(maddr);
        busy          <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (bus.ReadMiss) begin
      busy  <= 1'b1;
      cnt   <= LAT;
      maddr <= bus.Address;
    end
  end

  always @(posedge clk) begin
    if (bus.ReadMiss === 1'b1) rm_cnt++;
    if (bus.Abort === 1'b1) ab_cnt++;
    if (bus.ReadMiss === 1'b1 && bus.Abort === 1'b1) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ReadReady === 1'b1) break;
    end
    check("readready_seen", {31'd0, bus.ReadReady}, 32'd1);
  endtask

  // Called one cycle after the miss was presented: expects the request, then the hit.
  task automatic finish_fill(input logic [31:0] exp_addr, input logic [31:0] exp_instr);
    @(negedge clk); #1;
    check("req_readmiss", {31'd0, bus.ReadMiss}, 32'd1);
    check("req_address", bus.Address, exp_addr);
    wait_ready();
    @(negedge clk); #1;
    check("fill_stall", {31'd0, bus.Stall}, 32'd0);
    check("fill_instr", bus.Instr, exp_instr);
  endtask

  task automatic miss_fill(input logic [31:0] pc, input logic [31:0] exp_addr,
                           input logic [31:0] exp_instr);
    bus.PC = pc;
    #1;
    check("miss_stall", {31'd0, bus.Stall}, 32'd1);
    finish_fill(exp_addr, exp_instr);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic [31:0] instr;
  } vec_t;
  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b0, 1'b0, 32'hC0DE_0010};
    vecs[1] = '{32'h0000_0014, 1'b0, 1'b0, 32'hC0DE_0014};
    vecs[2] = '{32'h0000_0018, 1'b0, 1'b0, 32'hC0DE_0018};
    vecs[3] = '{32'h0000_001C, 1'b0, 1'b0, 32'hC0DE_001C};
    vecs[4] = '{32'h0000_001C, 1'b1, 1'b0, 32'hC0DE_001C};
    vecs[5] = '{32'h0000_0020, 1'b1, 1'b1, 32'h0000_0000};
    vecs[6] = '{32'h0000_0110, 1'b1, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'h0000_0018, 1'b0, 1'b0, 32'hC0DE_0018};

    rst       = 1'b1;
    bus.PC    = 32'h14;
    bus.Flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, bus.Stall}, 32'd1);
    check("rst_readmiss", {31'd0, bus.ReadMiss}, 32'd0);
    check("rst_abort", {31'd0, bus.Abort}, 32'd0);
    check("rst_address", bus.Address, 32'd0);

    // Cold fetch
    rst = 1'b0;
    miss_fill(32'h14, 32'h10, 32'hC0DE_0014);

    // Hits, plus flushed misses that must not request
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.PC    = vecs[i].pc;
      bus.Flush = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_stall", i), {31'd0, bus.Stall}, {31'd0, vecs[i].stall});
      if (!vecs[i].stall) check($sformatf("vec%0d_instr", i), bus.Instr, vecs[i].instr);
      check($sformatf("vec%0d_readmiss", i), {31'd0, bus.ReadMiss}, 32'd0);
    end
    bus.Flush = 1'b0;
    check("vec_no_request", rm_cnt, 1);

    // Conflict eviction
    @(negedge clk);
    miss_fill(32'h110, 32'h110, 32'hC0DE_0110);
    @(negedge clk);
    miss_fill(32'h10, 32'h10, 32'hC0DE_0010);

    // Abort in WAIT, then retry
    @(negedge clk);
    bus.PC = 32'h40;
    #1 check("abort_miss_stall", {31'd0, bus.Stall}, 32'd1);
    @(negedge clk); #1;
    check("abort_req", {31'd0, bus.ReadMiss}, 32'd1);
    repeat (5) @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    #1;
    check("abort_pulse", {31'd0, bus.Abort}, 32'd1);
    check("abort_no_readmiss", {31'd0, bus.ReadMiss}, 32'd0);
    @(negedge clk); #1;
    check("abort_one_cycle", {31'd0, bus.Abort}, 32'd0);
    check("abort_no_fill", {31'd0, bus.Stall}, 32'd1);
    finish_fill(32'h40, 32'hC0DE_0040);

    // Flush coincident with ReadReady
    @(negedge clk);
    bus.PC = 32'h80;
    #1 check("coinc_miss_stall", {31'd0, bus.Stall}, 32'd1);
    @(negedge clk); #1;
    check("coinc_req", {31'd0, bus.ReadMiss}, 32'd1);
    wait_ready();
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    #1;
    check("coinc_abort", {31'd0, bus.Abort}, 32'd0);
    check("coinc_stall", {31'd0, bus.Stall}, 32'd0);
    check("coinc_instr", bus.Instr, 32'hC0DE_0080);
    @(negedge clk); #1;
    check("coinc_abort_late", {31'd0, bus.Abort}, 32'd0);

    // Reset mid-WAIT
    @(negedge clk);
    bus.PC = 32'hC0;
    #1 check("rstw_miss_stall", {31'd0, bus.Stall}, 32'd1);
    @(negedge clk); #1;
    check("rstw_req", {31'd0, bus.ReadMiss}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    bus.PC = 32'h80;
    #1;
    check("rstw_stall", {31'd0, bus.Stall}, 32'd1);
    check("rstw_readmiss", {31'd0, bus.ReadMiss}, 32'd0);
    check("rstw_abort", {31'd0, bus.Abort}, 32'd0);
    check("rstw_address", bus.Address, 32'd0);
    finish_fill(32'h80, 32'hC0DE_0080);

    @(negedge clk);
    check("total_readmiss", rm_cnt, 8);
    check("total_abort", ab_cnt, 1);
    check("no_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
